// File: rtl/wb_unit.sv
// Writeback stage: registers one retiring instruction, formats load data and
// drives the register-file write port, retired-instruction count and load-timeout flag.
module wb_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  wb_sel,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [63:0] alu_res,
  input  logic [63:0] pc,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [63:0] instret,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        timeout_hit;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [2:0]  alo_q;
  logic [15:0] wait_cnt;
  logic [63:0] shifted;
  logic [63:0] load_data;
  logic [63:0] nonload_data;

  assign in_ready    = (state != WAIT_MEM);
  assign accept      = in_valid && in_ready;
  assign timeout_hit = (state == WAIT_MEM) && !dmem_rvalid &&
                       (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, WRITE: begin
        if (accept) state_nxt = (wb_sel == 2'b10) ? WAIT_MEM : WRITE;
        else        state_nxt = IDLE;
      end
      WAIT_MEM: begin
        if (dmem_rvalid)      state_nxt = WRITE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted = dmem_rdata >> {alo_q, 3'b000};
    unique case (f3_q)
      3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {56'd0, shifted[7:0]};
      3'b101:  load_data = {48'd0, shifted[15:0]};
      3'b110:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    unique case (wb_sel)
      2'b01:   nonload_data = alu_res;
      2'b11:   nonload_data = pc + 64'd4;
      default: nonload_data = '0;
    endcase
  end

  // Only the fields a pending load needs are kept; non-load results go
  // straight into the output registers at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      rd_q  <= '0;
      f3_q  <= '0;
      alo_q <= '0;
    end else if (accept) begin
      we_q  <= we;
      rd_q  <= rd;
      f3_q  <= funct3;
      alo_q <= addr_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               wait_cnt <= '0;
    else if (state == WAIT_MEM && state_nxt == WAIT_MEM)   wait_cnt <= wait_cnt + 16'd1;
    else                                                   wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      instret  <= '0;
      err      <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      if (state == WAIT_MEM && dmem_rvalid) begin
        rf_we    <= we_q && (rd_q != '0);
        rf_waddr <= rd_q;
        rf_wdata <= load_data;
      end else if (accept && wb_sel != 2'b10) begin
        rf_we    <= we && (rd != '0) && (wb_sel != 2'b00);
        rf_waddr <= rd;
        rf_wdata <= nonload_data;
      end
      if (state == WRITE) instret <= instret + 64'd1;
      if (timeout_hit)    err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases plus randomized traffic
// against an arithmetic reference model of the writeback rules.
module tb_wb_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        we;
  logic [4:0]  rd;
  logic [63:0] alu_res;
  logic [63:0] pc;
  logic [2:0]  funct3;
  logic [2:0]  addr_lo;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [63:0] instret;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret = '0;

  wb_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .we(we), .rd(rd), .alu_res(alu_res), .pc(pc),
    .funct3(funct3), .addr_lo(addr_lo), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .instret(instret), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic w, input logic [4:0] r,
                       input logic [63:0] a, input logic [63:0] p,
                       input logic [2:0] f, input logic [2:0] al);
    in_valid = 1'b1; wb_sel = s; we = w; rd = r;
    alu_res = a; pc = p; funct3 = f; addr_lo = al;
  endtask

  // Load result from size/signedness rules expressed as modular arithmetic.
  function automatic logic [63:0] load_model(input logic [63:0] d, input logic [2:0] f,
                                             input logic [2:0] a);
    int unsigned nbytes;
    bit          sgn;
    logic [63:0] v;
    logic [63:0] lim;
    case (f)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: begin nbytes = 4; sgn = 1'b1; end
      3'd4: begin nbytes = 1; sgn = 1'b0; end
      3'd5: begin nbytes = 2; sgn = 1'b0; end
      3'd6: begin nbytes = 4; sgn = 1'b0; end
      default: begin nbytes = 8; sgn = 1'b0; end
    endcase
    v = d >> (8 * int'(a));
    if (nbytes < 8) begin
      lim = 64'd1 << (8 * nbytes);
      v = v % lim;
      if (sgn && v >= (lim >> 1)) v = v - lim;
    end
    return v;
  endfunction

  task automatic do_nonload(input logic [1:0] s, input logic w, input logic [4:0] r,
                            input logic [63:0] a, input logic [63:0] p);
    logic        e_we;
    logic [63:0] e_d;
    e_we = w && (r != 0) && (s != 2'b00);
    e_d  = (s == 2'b01) ? a : (s == 2'b11) ? p + 64'd4 : 64'd0;
    chk("nl_ready", in_ready, 1);
    drive(s, w, r, a, p, 3'($urandom), 3'($urandom));
    tick();
    in_valid = 1'b0;
    chk("nl_we", rf_we, e_we);
    chk("nl_waddr", rf_waddr, r);
    chk("nl_wdata", rf_wdata, e_d);
    tick();
    exp_instret++;
    chk("nl_instret", instret, exp_instret);
    chk("nl_we_off", rf_we, 0);
    chk("nl_hold", rf_wdata, e_d);
  endtask

  task automatic do_load(input logic w, input logic [4:0] r, input logic [2:0] f,
                         input logic [2:0] al, input logic [63:0] data, input int d);
    drive(2'b10, w, r, {$urandom, $urandom}, {$urandom, $urandom}, f, al);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < d; i++) begin
      chk("ld_ready_low", in_ready, 0);
      chk("ld_we_wait", rf_we, 0);
      dmem_rdata = {$urandom, $urandom};
      tick();
    end
    chk("ld_ready_low_last", in_ready, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    tick();
    dmem_rvalid = 1'b0;
    chk("ld_we", rf_we, w && (r != 0));
    chk("ld_waddr", rf_waddr, r);
    chk("ld_wdata", rf_wdata, load_model(data, f, al));
    chk("ld_ready_back", in_ready, 1);
    tick();
    exp_instret++;
    chk("ld_instret", instret, exp_instret);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; wb_sel = '0; we = 1'b0; rd = '0;
    alu_res = '0; pc = '0; funct3 = '0; addr_lo = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_instret", instret, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1);

    do_nonload(2'b01, 1'b1, 5'd5, 64'h1234, 64'h0);
    do_nonload(2'b01, 1'b1, 5'd0, 64'h5678, 64'h0);
    do_nonload(2'b11, 1'b1, 5'd9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    do_nonload(2'b00, 1'b1, 5'd3, 64'hDEAD, 64'h100);
    do_nonload(2'b01, 1'b0, 5'd4, 64'hBEEF, 64'h100);

    do_load(1'b1, 5'd10, 3'b000, 3'd0, 64'h8877_6655_4433_2281, 3);
    do_load(1'b1, 5'd11, 3'b100, 3'd0, 64'h8877_6655_4433_2281, 3);
    do_load(1'b1, 5'd12, 3'b001, 3'd6, 64'h8877_6655_4433_2281, 3);
    do_load(1'b1, 5'd13, 3'b110, 3'd4, 64'h8877_6655_4433_2281, 3);
    do_load(1'b1, 5'd14, 3'b011, 3'd0, 64'h8877_6655_4433_2281, 1);
    do_load(1'b1, 5'd15, 3'b010, 3'd4, 64'h8877_6655_4433_2281, int'(TMO));

    for (int it = 0; it < 60; it++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      if (s == 2'b10)
        do_load(1'($urandom), 5'($urandom), 3'($urandom), 3'($urandom),
                {$urandom, $urandom}, int'($urandom_range(1, TMO)));
      else
        do_nonload(s, 1'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end

    // Load that never gets data: err rises after TMO waiting cycles.
    drive(2'b10, 1'b1, 5'd7, 64'h0, 64'h0, 3'b011, 3'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      chk("tmo_err_low", err, 0);
      chk("tmo_ready_low", in_ready, 0);
      tick();
    end
    chk("tmo_err_low_last", err, 0);
    tick();
    chk("tmo_err_set", err, 1);
    chk("tmo_ready", in_ready, 1);
    chk("tmo_no_write", rf_we, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("tmo_late_rvalid_we", rf_we, 0);
    chk("tmo_err_sticky", err, 1);
    tick();
    chk("tmo_instret", instret, exp_instret);

    // Reset in the middle of a pending load.
    drive(2'b10, 1'b1, 5'd8, 64'h0, 64'h0, 3'b000, 3'd0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_ready_low", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_err", err, 0);
    exp_instret = '0;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_after_we", rf_we, 0);
    chk("mid_after_ready", in_ready, 1);
    chk("mid_after_instret", instret, 0);

    // Three back-to-back ALU instructions.
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b1, 5'(i + 1), 64'(100 + i), 64'h0, 3'd0, 3'd0);
      tick();
      chk("b2b_we", rf_we, 1);
      chk("b2b_waddr", rf_waddr, 5'(i + 1));
      chk("b2b_wdata", rf_wdata, 64'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_we_off", rf_we, 0);
    chk("b2b_instret", instret, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
